// File: rtl/bp_cfg_loader.sv
// Config loader: streams one table entry to every core, optional per-write readback (BP_CFG_LOADER_READBACK_EN).
// Registered outputs, first beat the cycle after start; all cfg_* outputs hold while cfg_v_o=1 and cfg_ready_i=0.
module bp_cfg_loader #(
  parameter int num_cfgs_p       = 4,
  parameter int num_fields_p     = 8,
  parameter int num_core_p       = 2,
  parameter int cfg_data_width_p = 32,
  parameter int cfg_addr_width_p = 8,
  parameter int cfg_base_addr_p  = 'h10,
  parameter int rd_timeout_p     = 64
) (
  input  logic                                               clk_i,
  input  logic                                               reset_i,
  input  logic                                               start_v_i,
  input  logic [$clog2(num_cfgs_p)-1:0]                      cfg_sel_i,
  input  logic [num_cfgs_p*num_fields_p*cfg_data_width_p-1:0] cfg_table_i,
  output logic                                               cfg_v_o,
  output logic                                               cfg_w_o,
  output logic [$clog2(num_core_p)-1:0]                      cfg_core_o,
  output logic [cfg_addr_width_p-1:0]                        cfg_addr_o,
  output logic [cfg_data_width_p-1:0]                        cfg_data_o,
  input  logic                                               cfg_ready_i,
  input  logic                                               rdata_v_i,
  input  logic [cfg_data_width_p-1:0]                        rdata_i,
  output logic                                               busy_o,
  output logic                                               done_o,
  output logic                                               error_o,
  output logic [1:0]                                         err_code_o
);

  localparam int SW = $clog2(num_cfgs_p);
  localparam int CW = $clog2(num_core_p);
  localparam int FW = (num_fields_p > 1) ? $clog2(num_fields_p) : 1;
  localparam int DW = cfg_data_width_p;
  localparam int AW = cfg_addr_width_p;

`ifdef BP_CFG_LOADER_READBACK_EN
  localparam int TW = $clog2(rd_timeout_p + 1);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT_RD, S_DONE, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DONE, S_ERROR} state_t;
`endif

  state_t          r_state;
  logic [SW-1:0]   r_sel;
  logic [FW-1:0]   r_field;
`ifdef BP_CFG_LOADER_READBACK_EN
  logic [TW-1:0]   r_timer;
`endif

  logic            w_sel_bad;
  logic [SW-1:0]   w_start_sel;
  logic            w_last_field;
  logic            w_last_beat;
  logic [FW-1:0]   w_nxt_field;
  logic [CW-1:0]   w_nxt_core;
  logic [DW-1:0]   w_start_dat;
  logic [DW-1:0]   w_nxt_dat;
  logic            w_adv;

  assign w_sel_bad    = (cfg_sel_i == '0) || (int'(cfg_sel_i) >= num_cfgs_p);
  assign w_start_sel  = w_sel_bad ? '0 : cfg_sel_i;
  assign w_last_field = (r_field == FW'(num_fields_p - 1));
  assign w_last_beat  = w_last_field && (cfg_core_o == CW'(num_core_p - 1));
  assign w_nxt_field  = w_last_field ? '0 : r_field + FW'(1);
  assign w_nxt_core   = w_last_field ? cfg_core_o + CW'(1) : cfg_core_o;

  // Table is read live; the boot controller keeps it stable for the whole load.
  assign w_start_dat = cfg_table_i[(int'(w_start_sel) * num_fields_p) * DW +: DW];
  assign w_nxt_dat   = cfg_table_i[(int'(r_sel) * num_fields_p + int'(w_nxt_field)) * DW +: DW];

`ifdef BP_CFG_LOADER_READBACK_EN
  assign w_adv = (r_state == S_WAIT_RD) && rdata_v_i && (rdata_i == cfg_data_o);
`else
  assign w_adv = (r_state == S_WRITE) && cfg_ready_i;
  logic w_unused_rdata;
  assign w_unused_rdata = ^{rdata_v_i, rdata_i};
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_field    <= '0;
      cfg_v_o    <= 1'b0;
      cfg_w_o    <= 1'b0;
      cfg_core_o <= '0;
      cfg_addr_o <= '0;
      cfg_data_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      err_code_o <= 2'b00;
`ifdef BP_CFG_LOADER_READBACK_EN
      r_timer    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_v_i) begin
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            err_code_o <= 2'b00;
            r_sel      <= cfg_sel_i;
            r_field    <= '0;
            if (w_sel_bad) begin
              r_state    <= S_ERROR;
              error_o    <= 1'b1;
              err_code_o <= 2'b01;
            end else begin
              r_state    <= S_WRITE;
              cfg_v_o    <= 1'b1;
              cfg_w_o    <= 1'b1;
              busy_o     <= 1'b1;
              cfg_core_o <= '0;
              cfg_addr_o <= AW'(cfg_base_addr_p);
              cfg_data_o <= w_start_dat;
            end
          end
        end
`ifdef BP_CFG_LOADER_READBACK_EN
        S_WRITE: begin
          if (cfg_ready_i) begin
            r_state <= S_READ;
            cfg_w_o <= 1'b0;
          end
        end
        S_READ: begin
          // The handshake cycle counts as the first elapsed timeout cycle.
          if (cfg_ready_i) begin
            r_state <= S_WAIT_RD;
            cfg_v_o <= 1'b0;
            r_timer <= TW'(1);
          end
        end
        S_WAIT_RD: begin
          if (rdata_v_i) begin
            if (rdata_i != cfg_data_o) begin
              r_state    <= S_ERROR;
              busy_o     <= 1'b0;
              error_o    <= 1'b1;
              err_code_o <= 2'b10;
            end
          end else if (r_timer == TW'(rd_timeout_p - 1)) begin
            r_state    <= S_ERROR;
            busy_o     <= 1'b0;
            error_o    <= 1'b1;
            err_code_o <= 2'b11;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
`endif
        default: ;
      endcase

      if (w_adv) begin
        if (w_last_beat) begin
          r_state <= S_DONE;
          cfg_v_o <= 1'b0;
          cfg_w_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
        end else begin
          r_state    <= S_WRITE;
          cfg_v_o    <= 1'b1;
          cfg_w_o    <= 1'b1;
          r_field    <= w_nxt_field;
          cfg_core_o <= w_nxt_core;
          cfg_addr_o <= AW'(cfg_base_addr_p + int'(w_nxt_field));
          cfg_data_o <= w_nxt_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader; five table entries so that index 5 is out of range on a 3-bit select.
module tb_bp_cfg_loader;

  localparam int NC    = 5;
  localparam int NF    = 8;
  localparam int NCORE = 2;
  localparam int W     = 32;

  logic                 clk = 1'b0;
  logic                 reset_i;
  logic                 start_v_i;
  logic [2:0]           cfg_sel_i;
  logic [NC*NF*W-1:0]   cfg_table_i;
  logic                 cfg_v_o;
  logic                 cfg_w_o;
  logic [0:0]           cfg_core_o;
  logic [7:0]           cfg_addr_o;
  logic [31:0]          cfg_data_o;
  logic                 cfg_ready_i;
  logic                 rdata_v_i;
  logic [31:0]          rdata_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 error_o;
  logic [1:0]           err_code_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_cfg_loader #(
    .num_cfgs_p       (NC),
    .num_fields_p     (NF),
    .num_core_p       (NCORE),
    .cfg_data_width_p (W),
    .cfg_addr_width_p (8),
    .cfg_base_addr_p  ('h10),
    .rd_timeout_p     (64)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_v_i   (start_v_i),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_table_i (cfg_table_i),
    .cfg_v_o     (cfg_v_o),
    .cfg_w_o     (cfg_w_o),
    .cfg_core_o  (cfg_core_o),
    .cfg_addr_o  (cfg_addr_o),
    .cfg_data_o  (cfg_data_o),
    .cfg_ready_i (cfg_ready_i),
    .rdata_v_i   (rdata_v_i),
    .rdata_i     (rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .err_code_o  (err_code_o)
  );

  function automatic logic [31:0] ent(input int c, input int f);
    return {16'hC0DE, 8'(c), 8'(f)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_vwb"}, 32'({cfg_v_o, cfg_w_o, busy_o, done_o, error_o}), 32'd0);
    chk({tag, "_core_addr"}, 32'({cfg_core_o, cfg_addr_o}), 32'd0);
    chk({tag, "_data"}, cfg_data_o, 32'd0);
    chk({tag, "_code"}, 32'(err_code_o), 32'd0);
  endtask

`ifndef BP_CFG_LOADER_READBACK_EN
  // One write-only load; optional stall on one beat and a competing start pulse on another.
  task automatic run_load(input int sel, input int stall_beat, input int stall_n, input int poke_beat);
    int beat  = 0;
    int held  = 0;
    int cyc   = 0;
    int guard = 0;
    logic hs;
    cfg_sel_i = 3'(sel);
    start_v_i = 1'b1;
    tick;
    start_v_i = 1'b0;
    cyc = 1;
    chk("ld_err_clr", 32'({error_o, err_code_o}), 32'd0);
    while (beat < NCORE*NF && guard < 100) begin
      guard++;
      chk("ld_v_w_busy_done", 32'({cfg_v_o, cfg_w_o, busy_o, done_o}), 32'b1110);
      chk("ld_core", 32'(cfg_core_o), 32'(beat / NF));
      chk("ld_addr", 32'(cfg_addr_o), 32'('h10 + beat % NF));
      chk("ld_data", cfg_data_o, ent(sel, beat % NF));
      hs = !(beat == stall_beat && held < stall_n);
      if (!hs) held++;
      cfg_ready_i = hs;
      if (beat == poke_beat) begin
        start_v_i = 1'b1;
        cfg_sel_i = (sel == 1) ? 3'd2 : 3'd1;
      end
      tick;
      start_v_i = 1'b0;
      cyc++;
      if (hs) beat++;
    end
    cfg_ready_i = 1'b1;
    chk("ld_beats", 32'(beat), 32'(NCORE*NF));
    chk("ld_done_cycle", 32'(cyc), 32'(NCORE*NF + 1 + stall_n));
    chk("ld_end_flags", 32'({cfg_v_o, busy_o, done_o, error_o}), 32'b0010);
    tick;
    chk("ld_done_sticky", 32'({cfg_v_o, busy_o, done_o}), 32'b001);
  endtask
`endif

  initial begin
    int bad_sel[3] = '{0, 5, 7};
    reset_i     = 1'b1;
    start_v_i   = 1'b0;
    cfg_sel_i   = 3'd0;
    cfg_ready_i = 1'b1;
    rdata_v_i   = 1'b0;
    rdata_i     = 32'd0;
    for (int c = 0; c < NC; c++)
      for (int f = 0; f < NF; f++)
        cfg_table_i[(c*NF + f)*W +: W] = ent(c, f);

    repeat (2) tick;
    chk_rst("rst_held");
    reset_i = 1'b0;
    tick;
    chk_rst("rst_idle");

`ifndef BP_CFG_LOADER_READBACK_EN
    run_load(2, -1, 0, -1);
    run_load(2, 5, 3, -1);
    run_load(3, -1, 0, 6);
`endif

    foreach (bad_sel[i]) begin
      cfg_sel_i = 3'(bad_sel[i]);
      start_v_i = 1'b1;
      tick;
      start_v_i = 1'b0;
      chk("bad_flags", 32'({cfg_v_o, busy_o, done_o, error_o}), 32'b0001);
      chk("bad_code", 32'(err_code_o), 32'd1);
      tick;
      chk("bad_hold", 32'({cfg_v_o, error_o, err_code_o}), 32'b0101);
    end

`ifndef BP_CFG_LOADER_READBACK_EN
    run_load(4, -1, 0, -1);
`endif

    cfg_sel_i = 3'd1;
    start_v_i = 1'b1;
    tick;
    start_v_i = 1'b0;
    repeat (2) tick;
    chk("mid_busy", 32'(busy_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk_rst("mid_rst");
    tick;
    reset_i = 1'b0;
    tick;
    chk_rst("post_rst");

`ifdef BP_CFG_LOADER_READBACK_EN
    cfg_sel_i = 3'd2;
    start_v_i = 1'b1;
    tick;
    start_v_i = 1'b0;
    for (int b = 0; b < NCORE*NF; b++) begin
      chk("rb_wr", 32'({cfg_v_o, cfg_w_o, cfg_core_o, cfg_addr_o}), 32'({2'b11, 1'(b / NF), 8'('h10 + b % NF)}));
      tick;
      chk("rb_rd", 32'({cfg_v_o, cfg_w_o, cfg_core_o, cfg_addr_o}), 32'({2'b10, 1'(b / NF), 8'('h10 + b % NF)}));
      tick;
      rdata_v_i = 1'b1;
      rdata_i   = ent(2, b % NF) ^ ((b == 11) ? 32'h1 : 32'h0);
      tick;
      rdata_v_i = 1'b0;
      if (b == 11) break;
    end
    chk("rb_mis_flags", 32'({cfg_v_o, busy_o, done_o, error_o}), 32'b0001);
    chk("rb_mis_code", 32'(err_code_o), 32'd2);
    chk("rb_mis_beat", 32'({cfg_core_o, cfg_addr_o}), 32'({1'b1, 8'h13}));

    cfg_sel_i = 3'd1;
    start_v_i = 1'b1;
    tick;
    start_v_i = 1'b0;
    tick;
    chk("rb_to_rd", 32'({cfg_v_o, cfg_w_o}), 32'b10);
    repeat (63) tick;
    chk("rb_to_early", 32'({busy_o, error_o}), 32'b10);
    tick;
    chk("rb_to_flags", 32'({busy_o, error_o}), 32'b01);
    chk("rb_to_code", 32'(err_code_o), 32'd3);
    chk("rb_to_beat", 32'({cfg_core_o, cfg_addr_o}), 32'({1'b0, 8'h10}));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
